// File: rtl/btn_debounce_scheduler.sv
// -----------------------------------------------------------------------------
// btn_debounce_scheduler
//
// Debounces N_BTN synchronized alarm-clock buttons using one shared stability
// timer. A round-robin scanner locks onto the first button whose raw level
// differs from its committed level. The change must then stay stable for
// DEBOUNCE_MS millisecond ticks. After that it is committed to btn_stable and
// reported as one press/release event.
//
// Optional feature macro: BTN_RELEASE_EVENTS_EN
//   defined   : press and release commits both produce an event.
//   undefined : only press commits produce an event. Release commits update
//               btn_stable silently, and evt_press is tied to 1.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst_n       in   synchronous reset, active-low
//   btn_raw     in   [N_BTN] synchronized raw levels, 1 = pressed
//   evt_valid   out  event pending
//   evt_ready   in   consumer accepts event
//   evt_id      out  [IDW] button index of the pending event
//   evt_press   out  1 = press, 0 = release
//   btn_stable  out  [N_BTN] committed debounced levels
//   busy        out  high while qualifying or emitting
//   bounce_cnt  out  [8] aborted qualifications, saturates at 255
//   state_dbg   out  [2] current FSM state (0 SCAN, 1 QUALIFY, 2 EMIT)
//
// Handshake: an event transfers on a clock edge where evt_valid && evt_ready.
// evt_valid stays high and evt_id/evt_press stay stable until that edge.
// evt_ready is ignored while evt_valid is low.
// -----------------------------------------------------------------------------
module btn_debounce_scheduler #(
    parameter int N_BTN       = 4,
    parameter int IDW         = 2,
    parameter int TICK_DIV    = 1000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDW-1:0]   evt_id,
    output logic             evt_press,
    output logic [N_BTN-1:0] btn_stable,
    output logic             busy,
    output logic [7:0]       bounce_cnt,
    output logic [1:0]       state_dbg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_MS + 1);

    typedef enum logic [1:0] {
        S_SCAN    = 2'd0,
        S_QUALIFY = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [MW-1:0]    ms_cnt_q, ms_cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             target_q, target_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [7:0]       bounce_q, bounce_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IDW-1:0]   evt_id_q, evt_id_d;
`ifdef BTN_RELEASE_EVENTS_EN
    logic             evt_press_q, evt_press_d;
`endif

    logic             tick;
    logic             emit_on_commit;

    // The prescaler runs freely. It is not realigned when a qualification
    // starts, so the first counted tick can come anywhere within the first ms.
    assign tick = (presc_q == PW'(TICK_DIV - 1));

`ifdef BTN_RELEASE_EVENTS_EN
    assign emit_on_commit = 1'b1;
`else
    assign emit_on_commit = target_q;
`endif

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
        return (idx == IDW'(N_BTN - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        ms_cnt_d    = ms_cnt_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        target_d    = target_q;
        stable_d    = stable_q;
        bounce_d    = bounce_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
`ifdef BTN_RELEASE_EVENTS_EN
        evt_press_d = evt_press_q;
`endif

        case (state_q)
            S_SCAN: begin
                if (btn_raw[ptr_q] != stable_q[ptr_q]) begin
                    id_d     = ptr_q;
                    target_d = btn_raw[ptr_q];
                    ms_cnt_d = '0;
                    state_d  = S_QUALIFY;
                end else begin
                    ptr_d = next_idx(ptr_q);
                end
            end

            S_QUALIFY: begin
                // Mismatch wins over a coincident tick: the change was not
                // stable for the whole window.
                if (btn_raw[id_q] != target_q) begin
                    bounce_d = (bounce_q == 8'hFF) ? bounce_q : bounce_q + 8'd1;
                    ptr_d    = next_idx(id_q);
                    state_d  = S_SCAN;
                end else if (tick) begin
                    if (ms_cnt_q == MW'(DEBOUNCE_MS - 1)) begin
                        stable_d[id_q] = target_q;
                        if (emit_on_commit) begin
                            state_d = S_EMIT;
                        end else begin
                            ptr_d   = next_idx(id_q);
                            state_d = S_SCAN;
                        end
                    end else begin
                        ms_cnt_d = ms_cnt_q + 1'b1;
                    end
                end
            end

            S_EMIT: begin
                // The first EMIT cycle raises evt_valid. This puts the
                // btn_stable update one cycle ahead of the event.
                if (!evt_valid_q) begin
                    evt_valid_d = 1'b1;
                    evt_id_d    = id_q;
`ifdef BTN_RELEASE_EVENTS_EN
                    evt_press_d = target_q;
`endif
                end else if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    ptr_d       = next_idx(id_q);
                    state_d     = S_SCAN;
                end
            end

            default: begin
                state_d = S_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_SCAN;
            presc_q     <= '0;
            ms_cnt_q    <= '0;
            ptr_q       <= '0;
            id_q        <= '0;
            target_q    <= 1'b0;
            stable_q    <= '0;
            bounce_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
`ifdef BTN_RELEASE_EVENTS_EN
            evt_press_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            ms_cnt_q    <= ms_cnt_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            target_q    <= target_d;
            stable_q    <= stable_d;
            bounce_q    <= bounce_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
`ifdef BTN_RELEASE_EVENTS_EN
            evt_press_q <= evt_press_d;
`endif
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
`ifdef BTN_RELEASE_EVENTS_EN
    assign evt_press  = evt_press_q;
`else
    assign evt_press  = 1'b1;
`endif
    assign btn_stable = stable_q;
    assign bounce_cnt = bounce_q;
    assign busy       = (state_q != S_SCAN);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_btn_debounce_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for btn_debounce_scheduler (N_BTN=4, TICK_DIV=4, DEBOUNCE_MS=3).
// Directed vectors with hand-computed expectations. Accepted events are
// checked against an expected queue of {id, press}.
// -----------------------------------------------------------------------------
module tb_btn_debounce_scheduler;

    localparam int N_BTN       = 4;
    localparam int IDW         = 2;
    localparam int TICK_DIV    = 4;
    localparam int DEBOUNCE_MS = 3;
`ifdef BTN_RELEASE_EVENTS_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    // clock / reset
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_BTN-1:0] btn_raw = '0;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [IDW-1:0]   evt_id;
    logic             evt_press;
    logic [N_BTN-1:0] btn_stable;
    logic             busy;
    logic [7:0]       bounce_cnt;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    btn_debounce_scheduler #(
        .N_BTN(N_BTN), .IDW(IDW), .TICK_DIV(TICK_DIV), .DEBOUNCE_MS(DEBOUNCE_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_press(evt_press), .btn_stable(btn_stable), .busy(busy),
        .bounce_cnt(bounce_cnt), .state_dbg(state_dbg)
    );

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [IDW:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transfer happens at the next posedge when valid && ready at the negedge.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", {29'd0, evt_id, evt_press}, 32'hFFFF_FFFF);
            end else begin
                check("evt_id_press", {29'd0, evt_id, evt_press}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        while (!evt_valid && n < max_cyc) begin
            step(1);
            n++;
        end
        check(tag, {31'd0, evt_valid}, 32'd1);
    endtask

    task automatic accept();
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check("accept_drop", {31'd0, evt_valid}, 32'd0);
    endtask

    task automatic do_reset(input logic [N_BTN-1:0] raw_after);
        rst_n   = 1'b0;
        btn_raw = '0;
        step(1);
        rst_n   = 1'b1;
        btn_raw = raw_after;
    endtask

    initial begin : main
        int c;
        int seen;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        step(2);
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_stable", {28'd0, btn_stable}, 32'd0);
        check("rst_bounce", {24'd0, bounce_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_id", {30'd0, evt_id}, 32'd0);
        check("rst_press", {31'd0, evt_press}, REL_EN ? 32'd0 : 32'd1);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        rst_n = 1'b1;

        // ---------------- clean press ----------------
        btn_raw = 4'b0100;
        c = 0;
        while (!busy && c < 8) begin step(1); c++; end
        check("press_detect", {31'd0, busy}, 32'd1);
        c = 0;
        while (!btn_stable[2] && c < 20) begin step(1); c++; end
        check("press_latency_9_12", {31'd0, (c >= 9 && c <= 12)}, 32'd1);
        check("stable_before_valid", {31'd0, evt_valid}, 32'd0);
        step(1);
        check("press_valid", {31'd0, evt_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, evt_valid}, 32'd1);
            check("hold_id", {30'd0, evt_id}, 32'd2);
            check("hold_press", {31'd0, evt_press}, 32'd1);
            check("hold_busy", {31'd0, busy}, 32'd1);
            step(1);
        end
        exp_q.push_back({2'd2, 1'b1});
        accept();
        check("press_stable", {28'd0, btn_stable}, 32'h4);
        check("press_busy_after", {31'd0, busy}, 32'd0);

        // ---------------- bounce abort ----------------
        seen = 0;
        for (int seg = 0; seg < 6; seg++) begin
            btn_raw[1] = (seg % 2 == 0);
            for (int k = 0; k < 5; k++) begin
                step(1);
                if (evt_valid) seen++;
            end
        end
        check("bounce_no_evt", seen, 0);
        check("bounce_cnt_3", {24'd0, bounce_cnt}, 32'd3);
        btn_raw[1] = 1'b1;
        exp_q.push_back({2'd1, 1'b1});
        wait_valid("bounce_evt_seen", 40);
        accept();
        check("bounce_stable", {28'd0, btn_stable}, 32'h6);

        // ---------------- fairness ----------------
        do_reset(4'b1001);
        exp_q.push_back({2'd0, 1'b1});
        exp_q.push_back({2'd3, 1'b1});
        wait_valid("fair_first_seen", 40);
        check("fair_first_id", {30'd0, evt_id}, 32'd0);
        accept();
        wait_valid("fair_second_seen", 40);
        check("fair_second_id", {30'd0, evt_id}, 32'd3);
        accept();
        check("fair_stable", {28'd0, btn_stable}, 32'h9);

        // ---------------- tick/mismatch collision ----------------
        // Lock at edge R0+1, ticks counted at R0+4, R0+8, commit tick R0+12.
        do_reset(4'b0001);
        step(11);
        check("coll_qualifying", {31'd0, busy}, 32'd1);
        btn_raw = 4'b0000;
        step(1);
        check("coll_bounce", {24'd0, bounce_cnt}, 32'd1);
        check("coll_no_commit", {28'd0, btn_stable}, 32'd0);
        check("coll_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (evt_valid || btn_stable != 4'd0) seen++;
        end
        check("coll_quiet", seen, 0);

        // ---------------- reset during EMIT ----------------
        btn_raw = 4'b0001;
        wait_valid("emit_before_rst", 40);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
        check("mid_rst_stable", {28'd0, btn_stable}, 32'd0);
        check("mid_rst_bounce", {24'd0, bounce_cnt}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        exp_q.push_back({2'd0, 1'b1});
        wait_valid("requalify_seen", 40);
        accept();
        check("requalify_stable", {28'd0, btn_stable}, 32'h1);

        // ---------------- release ----------------
        btn_raw = 4'b0000;
        c = 0;
        while (btn_stable[0] && c < 30) begin step(1); c++; end
        check("release_stable", {28'd0, btn_stable}, 32'd0);
        if (REL_EN) begin
            exp_q.push_back({2'd0, 1'b0});
            wait_valid("release_evt_seen", 10);
            check("release_press", {31'd0, evt_press}, 32'd0);
            accept();
        end else begin
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                step(1);
                if (evt_valid) seen++;
            end
            check("release_no_evt", seen, 0);
            check("release_press_tied", {31'd0, evt_press}, 32'd1);
        end

        // ---------------- bounce_cnt saturation ----------------
        do_reset(4'b0000);
        for (int k = 0; k < 300; k++) begin
            btn_raw[3] = 1'b1;
            step(5);
            btn_raw[3] = 1'b0;
            step(1);
        end
        check("bounce_saturate", {24'd0, bounce_cnt}, 32'd255);
        check("sat_stable", {28'd0, btn_stable}, 32'd0);
        check("sat_valid", {31'd0, evt_valid}, 32'd0);

        // ---------------- final report ----------------
        step(2);
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_debounce_scheduler.md
Name: btn_debounce_scheduler

Overview:
- Shares one debounce stability timer among N_BTN synchronized alarm-clock buttons (hour, minute, alarm, snooze).
- Scans the buttons round-robin and locks onto the first button whose raw level differs from its committed level.
- Qualifies that change over DEBOUNCE_MS millisecond ticks, then commits it and emits a single press/release event over a valid/ready handshake.
- Sits between the button input synchronizers (and the noise-injection bench model) and the alarm-clock control FSM.

Parameters:
- N_BTN, 4, number of buttons; 2..16.
- IDW, 2, width of evt_id; must equal clog2(N_BTN).
- TICK_DIV, 1000, clk cycles per 1 ms tick (1 MHz clk); >=2.
- DEBOUNCE_MS, 20, ticks of uninterrupted stability required to commit; >=1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- btn_raw  in  N_BTN  synchronized raw levels; 1 = pressed.
- evt_valid  out  1  event pending.
- evt_ready  in  1  consumer accepts event.
- evt_id  out  IDW  button index of the pending event.
- evt_press  out  1  1 = press, 0 = release.
- btn_stable  out  N_BTN  committed debounced levels.
- busy  out  1  high in QUALIFY or EMIT.
- bounce_cnt  out  8  aborted qualifications; saturates at 255.

Behaviour:
- Reset: while rst_n==0 at posedge, all outputs go to 0, state=SCAN, ptr=0, prescaler=0, ms_cnt=0. A pending event or qualification in progress is discarded.
- Tick generator:
  - Free-running prescaler 0..TICK_DIV-1.
  - tick is a 1-cycle pulse when prescaler==TICK_DIV-1; it then wraps to 0.
  - Runs in all states and is not re-aligned at qualification start. Effective qualify time is therefore (DEBOUNCE_MS-1, DEBOUNCE_MS] ms.
- State SCAN:
  - Each cycle, examine index ptr.
  - If btn_raw[ptr] != btn_stable[ptr]: lock id=ptr, target=btn_raw[ptr], ms_cnt=0, go to QUALIFY.
  - Otherwise ptr = (ptr==N_BTN-1) ? 0 : ptr+1.
  - Worst-case detect latency: N_BTN cycles.
- State QUALIFY:
  - Mismatch: if btn_raw[id] != target, abort. bounce_cnt++ (saturating), ptr=next(id), go to SCAN.
  - Tick without mismatch: ms_cnt++.
  - Commit: when ms_cnt would reach DEBOUNCE_MS, set btn_stable[id]=target the same cycle, then go to EMIT (or to SCAN if the event is suppressed; see Optional Feature).
  - A mismatch and a tick in the same cycle resolve as abort; mismatch has priority.
  - Other buttons are ignored while in QUALIFY. Their changes are picked up on later scans.
  - ms_cnt width is clog2(DEBOUNCE_MS+1).
- State EMIT:
  - evt_valid=1; evt_id=id and evt_press=target, held stable until the handshake.
  - On evt_valid && evt_ready, the next cycle has evt_valid=0, state=SCAN, ptr=next(id). This guarantees round-robin fairness.
  - No scanning or qualification occurs while in EMIT.
  - evt_ready while evt_valid==0 is ignored.
- Event ordering:
  - evt_id and evt_press hold their last values when evt_valid==0.
  - btn_stable updates exactly one cycle before evt_valid rises.
  - A button released during EMIT is caught on a later scan as a separate release event.

Optional Feature:
- Macro: BTN_RELEASE_EVENTS_EN.
- Defined: both press (target=1) and release (target=0) commits produce an event via EMIT.
- Undefined: only press commits enter EMIT. Release commits still update btn_stable, then go directly to SCAN with ptr=next(id), and evt_press is tied to 1.

Test Plan:
All scenarios use N_BTN=4, TICK_DIV=4, DEBOUNCE_MS=3, and BTN_RELEASE_EVENTS_EN defined unless noted.
- Clean press: drive btn_raw=4'b0100 and hold. Required: btn_stable[2]=1 within 9..12 cycles of detect, then evt_valid=1, evt_id=2, evt_press=1 held for 5 cycles with evt_ready=0. With evt_ready=1, evt_valid=0 the next cycle.
- Bounce abort: btn_raw[1] toggles 1,0,1 with a 5-cycle period for 30 cycles, then holds 1. Required: bounce_cnt >= 2, exactly one event (id=1, press=1), no event during the toggling.
- Fairness: raise btn_raw[0] and btn_raw[3] on the same cycle, with ptr=0. Required: event id=0, then id=3; btn_stable=4'b1001 after both.
- Tick/mismatch collision: drop btn_raw[id] in the same cycle as a tick during QUALIFY. Required: abort, bounce_cnt+1, no commit.
- Reset mid-operation: assert rst_n=0 for 1 cycle while in EMIT. Required: evt_valid=0, btn_stable=0, bounce_cnt=0, busy=0. The still-pressed button is re-qualified and emitted again.
- Macro off: press then release btn_raw[0]. Required: only the press event appears; btn_stable[0] returns to 0; evt_valid stays 0 on release.
